// File: rtl/data_producer.sv
// AXI-Stream test-traffic source: emits a programmed number of fixed-length packets
// tagged with a run-wide cycle_id and packet_id, with optional idle gaps between packets.
module data_producer #(
    parameter int PACKET_BEATS = 64,
    parameter int GAP_CYCLES   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [31:0]  packet_count,
    output logic         busy,
    output logic         done,
    output logic [511:0] AXIS_TX_TDATA,
    output logic         AXIS_TX_TVALID,
    output logic         AXIS_TX_TLAST,
    input  logic         AXIS_TX_TREADY
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [15:0] LAST_BEAT = 16'(PACKET_BEATS - 1);
    localparam logic [31:0] LAST_GAP  = 32'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_cycleId;
    logic [31:0] r_packetId;
    logic [15:0] r_beatIdx;
    logic [31:0] r_pktCount;
    logic [31:0] r_gapCnt;
    logic        r_done;

    logic w_accept;
    logic w_doneNext;
    logic w_xfer;
    logic w_lastBeat;
    logic w_finalPkt;

    assign w_lastBeat = (r_beatIdx == LAST_BEAT);
    assign w_finalPkt = (r_packetId == r_pktCount - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A start landing on the done cycle belongs to the finishing run and is dropped.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_doneNext  = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !r_done) begin
                    if (packet_count != 32'd0) begin
                        w_accept    = 1'b1;
                        w_nextState = SEND;
                    end else begin
                        w_doneNext = 1'b1;
                    end
                end
            end
            SEND: begin
                if (AXIS_TX_TREADY) begin
                    w_xfer = 1'b1;
                    if (w_lastBeat) begin
                        if (w_finalPkt) begin
                            w_nextState = IDLE;
                            w_doneNext  = 1'b1;
                        end else if (GAP_CYCLES != 0) begin
                            w_nextState = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (r_gapCnt == LAST_GAP) begin
                    w_nextState = SEND;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycleId  <= '0;
            r_packetId <= '0;
            r_beatIdx  <= '0;
            r_pktCount <= '0;
            r_gapCnt   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_doneNext;
            if (w_accept) begin
                r_pktCount <= packet_count;
                r_cycleId  <= '0;
                r_packetId <= '0;
                r_beatIdx  <= '0;
                r_gapCnt   <= '0;
            end
            if (w_xfer) begin
                r_cycleId <= r_cycleId + 32'd1;
                r_gapCnt  <= '0;
                if (w_lastBeat) begin
                    r_beatIdx <= '0;
                    if (!w_finalPkt) begin
                        r_packetId <= r_packetId + 32'd1;
                    end
                end else begin
                    r_beatIdx <= r_beatIdx + 16'd1;
                end
            end
            if (r_state == GAP) begin
                r_gapCnt <= r_gapCnt + 32'd1;
            end
        end
    end

    // Outputs decode registered state only, so TREADY never reaches them combinationally.
    assign busy           = (r_state != IDLE);
    assign done           = r_done;
    assign AXIS_TX_TVALID = (r_state == SEND);
    assign AXIS_TX_TLAST  = (r_state == SEND) && w_lastBeat;
    assign AXIS_TX_TDATA  = {416'd0, r_packetId, 16'd0, r_beatIdx, r_cycleId};

endmodule

// File: doc/data_producer.md
Name: data_producer

Overview:
- Test-traffic source that feeds the receive-side consumer stage over a 512-bit AXI-Stream link.
- On a start pulse, it emits a programmed number of fixed-length packets.
- Every beat carries a running cycle_id in bits [31:0] and a packet_id in bits [95:64], so the downstream stage can track sequence and detect gaps.
- It fully honours TREADY backpressure, and can insert an idle gap between packets.

Parameters:
PACKET_BEATS, 64, beats per packet (legal range 1..65535)
GAP_CYCLES, 0, idle cycles with TVALID low inserted between consecutive packets (0 = back-to-back)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a run when idle
packet_count  in  32  number of packets in the run; sampled only on an accepted start
busy  out  1  high from the cycle after an accepted start until the run finishes
done  out  1  one-cycle pulse when a run finishes
AXIS_TX_TDATA  out  512  stream data
AXIS_TX_TVALID  out  1  stream valid
AXIS_TX_TLAST  out  1  high on the final beat of each packet
AXIS_TX_TREADY  in  1  downstream ready

Behaviour:
- Reset values (asserted in any state): busy=0, done=0, TVALID=0, TLAST=0, TDATA=0, all internal counters=0, state=IDLE.
- Beat layout:
  - TDATA[31:0] = cycle_id: global beat index within the run, starting at 0.
  - TDATA[63:32] = beat index within the current packet, 0..PACKET_BEATS-1.
  - TDATA[95:64] = packet_id: index within the run, starting at 0.
  - TDATA[511:96] = 0.
- State machine: IDLE, SEND, GAP.
- IDLE:
  - start=1 with packet_count!=0: latch the count, clear cycle_id and packet_id, go to SEND. TVALID and busy are asserted on the next cycle, so first-beat latency is 1 clock.
  - start=1 with packet_count==0: stay in IDLE, pulse done on the next cycle, no traffic, busy stays 0.
- SEND:
  - TVALID=1.
  - A beat transfers on a rising clock edge when TVALID=1 and TREADY=1. On each transfer, cycle_id and the in-packet beat index advance.
  - While TVALID=1 and TREADY=0, TDATA and TLAST hold exactly stable. TVALID never drops without a transfer.
  - TLAST=1 exactly when the in-packet index equals PACKET_BEATS-1. With PACKET_BEATS=1, every beat has TLAST=1.
  - On the TLAST transfer:
    - If this was the final packet: go to IDLE, drop TVALID and busy next cycle, pulse done for one cycle.
    - Else if GAP_CYCLES=0: stay in SEND with TVALID continuously high; packet_id increments and the in-packet index resets to 0.
    - Else: go to GAP.
- GAP:
  - TVALID=0 for exactly GAP_CYCLES clocks, then return to SEND with the incremented packet_id.
- start while busy is ignored, including on the same cycle done pulses. A start accepted in IDLE on the cycle after done is legal.
- Counter widths and wrap:
  - cycle_id and packet_id are 32-bit and wrap modulo 2^32.
  - The packet counter compares against the latched packet_count. packet_count = 0xFFFFFFFF is legal.
- Reset mid-run: TVALID falls on the next edge, busy=0, no done pulse, partial packet abandoned. The next run restarts at id 0.
- TREADY is not used combinationally to drive any output other than via registered state. All outputs are registered.

Test Plan:
- PACKET_BEATS=4, GAP_CYCLES=0, packet_count=3, TREADY=1:
  - TVALID high for 12 consecutive cycles starting 1 cycle after start.
  - cycle_id 0..11; packet_id 0,0,0,0,1,...,2.
  - TLAST on cycle_ids 3, 7, 11; done pulses once the cycle after beat 11; busy low thereafter.
- Same config with TREADY random ~50%: exactly 12 transfers with identical content; TDATA/TLAST stable on every stalled cycle; no dropped or duplicated beats.
- PACKET_BEATS=2, GAP_CYCLES=3, packet_count=2, TREADY=1: beats 0,1, then 3 cycles TVALID=0, then beats 2,3 with packet_id=1, then done.
- packet_count=0: done pulses one cycle after start; TVALID never rises; busy stays 0.
- Assert reset after 5 beats of a 3x4 run: TVALID=0 next cycle, no done. A new start with packet_count=1 emits cycle_id 0, packet_id 0.
- start pulsed mid-run and PACKET_BEATS=1 with packet_count=5: the mid-run start is ignored, with the total beat count unchanged. All 5 beats carry TLAST=1 with packet_id 0..4.
